// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if
// Command handshake bundle for counter_sequencer.
//   cmd_valid  requester -> sequencer  command present
//   cmd_ready  sequencer -> requester  sequencer can take a command
//   cmd_dir    requester -> sequencer  0 = count up, 1 = count down
//   cmd_limit  requester -> sequencer  terminal/reload value of each pass
//   cmd_reps   requester -> sequencer  number of passes (0 means 16)
// master: the requester side. slave: the sequencer side.
interface counter_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_limit;
  logic [3:0]       cmd_reps;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_limit,
    output cmd_reps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_limit,
    input  cmd_reps,
    output cmd_ready
  );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer
// Runs a WIDTH-bit counter through a programmed number of up or down passes
// in response to one command at a time.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   cmd    command handshake (slave side of counter_sequencer_if)
//   hold   freeze the counter while high (RUN only)
//   abort  end the current run early (LOAD/RUN only)
//   out    counter value (registered)
//   busy   run in progress
//   wrap   pass-end pulse, high in the cycle out shows the terminal value
//   done   one-cycle run-complete pulse (registered)
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  counter_sequencer_if.slave   cmd,
  input  logic                 hold,
  input  logic                 abort,
  output logic [WIDTH-1:0]     out,
  output logic                 busy,
  output logic                 wrap,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] out_r, out_next_s;
  logic [3:0]       pass_cnt_r, pass_next_s;
  logic             dir_r, dir_next_s;
  logic [WIDTH-1:0] limit_r, limit_next_s;
  logic [3:0]       reps_r, reps_next_s;
  logic             done_r;
  logic             wrap_s;
  logic [WIDTH-1:0] start_s;
  logic [WIDTH-1:0] term_s;

  // Each pass starts at the opposite end from where it terminates.
  assign start_s = dir_r ? limit_r : CNT_ZERO;
  assign term_s  = dir_r ? CNT_ZERO : limit_r;

  // Next-state, next-counter and wrap decode.
  always_comb begin
    state_next_s = state_r;
    out_next_s   = out_r;
    pass_next_s  = pass_cnt_r;
    dir_next_s   = dir_r;
    limit_next_s = limit_r;
    reps_next_s  = reps_r;
    wrap_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          dir_next_s   = cmd.cmd_dir;
          limit_next_s = cmd.cmd_limit;
          reps_next_s  = cmd.cmd_reps;
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_next_s = ST_DONE;
        end else begin
          out_next_s   = start_s;
          pass_next_s  = 4'd0;
          state_next_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next_s = ST_DONE;
        end else if (hold) begin
          state_next_s = ST_RUN;
        end else if (out_r != term_s) begin
          out_next_s = dir_r ? (out_r - CNT_ONE) : (out_r + CNT_ONE);
        end else begin
          wrap_s = 1'b1;
          // 4-bit compare: reps=0 makes the last pass index 15, i.e. 16 passes.
          if (pass_cnt_r == (reps_r - 4'd1)) begin
            state_next_s = ST_DONE;
          end else begin
            out_next_s  = start_s;
            pass_next_s = pass_cnt_r + 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      out_r      <= CNT_ZERO;
      pass_cnt_r <= 4'd0;
      dir_r      <= 1'b0;
      limit_r    <= CNT_ZERO;
      reps_r     <= 4'd0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      out_r      <= out_next_s;
      pass_cnt_r <= pass_next_s;
      dir_r      <= dir_next_s;
      limit_r    <= limit_next_s;
      reps_r     <= reps_next_s;
      done_r     <= (state_next_s == ST_DONE);
    end
  end

  assign cmd.cmd_ready = (state_r == ST_IDLE);
  assign busy          = (state_r != ST_IDLE);
  assign out           = out_r;
  assign wrap          = wrap_s;
  assign done          = done_r;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
// Self-checking bench for counter_sequencer: directed scenarios followed by
// randomized runs, each compared cycle by cycle against a trace computed from
// the run parameters and the per-cycle hold/abort schedule.
module tb_counter_sequencer;
  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             wrap;
  logic             done;

  counter_sequencer_if #(.WIDTH(WIDTH)) cif ();

  counter_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cif),
    .hold  (hold),
    .abort (abort),
    .out   (out),
    .busy  (busy),
    .wrap  (wrap),
    .done  (done)
  );

  typedef struct {
    int out;
    bit wrap;
    bit done;
    bit busy;
    bit ready;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   last_out = 0;
  int   run_id = 0;
  bit   hold_a[1024];
  bit   abort_a[1024];
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int o, input bit w, input bit d, input bit b, input bit r);
    exp_t e;
    e.out = o; e.wrap = w; e.done = d; e.busy = b; e.ready = r;
    exp_q.push_back(e);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 1024; i++) begin
      hold_a[i]  = 1'b0;
      abort_a[i] = 1'b0;
    end
  endtask

  // DONE cycle followed by the first IDLE cycle, counter parked at v.
  task automatic finish_run(input int v);
    push(v, 1'b0, 1'b1, 1'b1, 1'b0);
    push(v, 1'b0, 1'b0, 1'b0, 1'b1);
    last_out = v;
  endtask

  // Expected trace from the cycle after acceptance (index 0 = LOAD) to the
  // first IDLE cycle: walk passes and values, stretching on hold, cutting on abort.
  task automatic build_expect(input bit d, input int lim, input int reps, input int prev);
    int passes;
    int cyc;
    int v;
    exp_q.delete();
    passes = (reps == 0) ? 16 : reps;
    if (abort_a[0]) begin
      push(prev, 1'b0, 1'b0, 1'b1, 1'b0);
      finish_run(prev);
      return;
    end
    push(prev, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc = 1;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k <= lim; k++) begin
        v = d ? (lim - k) : k;
        while (hold_a[cyc] && !abort_a[cyc]) begin
          push(v, 1'b0, 1'b0, 1'b1, 1'b0);
          cyc++;
        end
        if (abort_a[cyc]) begin
          push(v, 1'b0, 1'b0, 1'b1, 1'b0);
          finish_run(v);
          return;
        end
        push(v, (k == lim), 1'b0, 1'b1, 1'b0);
        cyc++;
      end
    end
    finish_run(d ? 0 : lim);
  endtask

  // Issue one command (or continue one accepted in the previous cycle) and
  // check every cycle up to and including the first IDLE cycle. With keep_next
  // the next command is presented from LOAD onward and must wait for IDLE.
  task automatic do_run(input bit d, input int lim, input int reps, input bit pre_accepted,
                        input bit keep_next, input bit nd, input int nl, input int nr);
    build_expect(d, lim, reps, last_out);
    run_id++;
    if (!pre_accepted) begin
      cif.cmd_valid = 1'b1;
      cif.cmd_dir   = d;
      cif.cmd_limit = lim[WIDTH-1:0];
      cif.cmd_reps  = reps[3:0];
      hold  = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk($sformatf("r%0d_accept_ready", run_id), {31'd0, cif.cmd_ready}, 32'd1);
      chk($sformatf("r%0d_accept_busy", run_id), {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
    if (keep_next) begin
      cif.cmd_valid = 1'b1;
      cif.cmd_dir   = nd;
      cif.cmd_limit = nl[WIDTH-1:0];
      cif.cmd_reps  = nr[3:0];
    end else begin
      cif.cmd_valid = 1'b0;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      hold  = hold_a[i];
      abort = abort_a[i];
      @(negedge clk);
      chk($sformatf("r%0d_c%0d_out", run_id, i), {28'd0, out}, exp_q[i].out);
      chk($sformatf("r%0d_c%0d_wrap", run_id, i), {31'd0, wrap}, {31'd0, exp_q[i].wrap});
      chk($sformatf("r%0d_c%0d_done", run_id, i), {31'd0, done}, {31'd0, exp_q[i].done});
      chk($sformatf("r%0d_c%0d_busy", run_id, i), {31'd0, busy}, {31'd0, exp_q[i].busy});
      chk($sformatf("r%0d_c%0d_ready", run_id, i), {31'd0, cif.cmd_ready}, {31'd0, exp_q[i].ready});
      @(posedge clk); #1;
    end
    hold  = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int d;
    int lim;
    int reps;
    int passes;
    int total;

    rst_n         = 1'b1;
    hold          = 1'b0;
    abort         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_dir   = 1'b0;
    cif.cmd_limit = 4'd0;
    cif.cmd_reps  = 4'd0;

    // Reset pulse of 4 ns between clock edges; values must clear without an edge.
    #6 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    #1;
    chk("rst_out", {28'd0, out}, 32'd0);
    chk("rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);
    last_out = 0;
    @(posedge clk); #1;

    // Up run, limit 3, two passes.
    clear_stim();
    do_run(1'b0, 3, 2, 1'b0, 1'b0, 1'b0, 0, 0);

    // Down run, limit 5, one pass, hold for two cycles while out=3.
    clear_stim();
    hold_a[3] = 1'b1;
    hold_a[4] = 1'b1;
    do_run(1'b1, 5, 1, 1'b0, 1'b0, 1'b0, 0, 0);

    // 16-pass up run to 15, aborted at out=7 of the second pass.
    clear_stim();
    abort_a[24] = 1'b1;
    do_run(1'b0, 15, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    // limit=0, three passes, with the next command held valid throughout.
    clear_stim();
    do_run(1'b0, 0, 3, 1'b0, 1'b1, 1'b1, 2, 1);
    clear_stim();
    do_run(1'b1, 2, 1, 1'b1, 1'b0, 1'b0, 0, 0);

    // Abort sampled in LOAD.
    clear_stim();
    abort_a[0] = 1'b1;
    do_run(1'b1, 6, 2, 1'b0, 1'b0, 1'b0, 0, 0);

    // Reset mid-run while out=9.
    cif.cmd_valid = 1'b1;
    cif.cmd_dir   = 1'b0;
    cif.cmd_limit = 4'd12;
    cif.cmd_reps  = 4'd1;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrst_pre_out", {28'd0, out}, 32'd9);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out", {28'd0, out}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, cif.cmd_ready}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_after%0d_done", i), {31'd0, done}, 32'd0);
      chk($sformatf("midrst_after%0d_busy", i), {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    last_out = 0;
    clear_stim();
    do_run(1'b0, 4, 2, 1'b0, 1'b0, 1'b0, 0, 0);

    // Randomized runs with random hold and occasional abort.
    for (int r = 0; r < 12; r++) begin
      clear_stim();
      d      = $urandom_range(0, 1);
      lim    = $urandom_range(0, 15);
      reps   = $urandom_range(0, 15);
      passes = (reps == 0) ? 16 : reps;
      total  = 1 + passes * (lim + 1);
      for (int i = 1; i < 700; i++) begin
        hold_a[i] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        abort_a[$urandom_range(0, total - 1)] = 1'b1;
      end
      do_run(d[0], lim, reps, 1'b0, 1'b0, 1'b0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
